lc3_pipe_controller: RTL and testbench

- Central hazard and sequencing controller for the LC3-2 five-stage pipeline: fetch, decode, execute, memaccess, writeback.
- Compares the decode-stage IR against the execute-stage IR_Exec.
- Drives the stage enables, the execute-stage bypass selects, branch resolution (br_taken) and the memaccess state sequence (mem_state).
- Sits beside the datapath; all of its outputs feed pipeline stage enables or muxes.

---
 rtl/lc3_pipe_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_lc3_pipe_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_pipe_controller.sv
// ============================================================================
// lc3_pipe_controller
// Hazard and sequencing controller for the LC3-2 five-stage pipeline
// (fetch, decode, execute, memaccess, writeback). Compares the decode-stage
// instruction against the execute-stage instruction and produces stage
// enables, execute-stage bypass selects, branch redirect and the memaccess
// state sequence.
//
// Ports
//   clk              in   pipeline clock, rising edge
//   rst              in   asynchronous active-low reset
//   complete_instr   in   instruction memory returned fetch data this cycle
//   complete_data    in   data memory finished the current mem_state access
//   IR[15:0]         in   instruction in decode
//   IR_Exec[15:0]    in   instruction in execute
//   NZP[2:0]         in   branch condition from execute (000 when not BR)
//   psr[2:0]         in   current condition codes {N,Z,P}
//   enable_updatePC  out  PC register update
//   enable_fetch     out  fetch stage enable
//   enable_decode    out  decode stage enable
//   enable_execute   out  execute stage enable
//   enable_writeback out  writeback stage enable
//   bypass_alu_1/2   out  execute src1/src2 take previous aluout
//   bypass_mem_1/2   out  execute src1/src2 take memory data
//   br_taken         out  redirect PC to pcout
//   mem_state[1:0]   out  0=read, 1=indirect read, 2=write, MEM_IDLE=idle
//
// Only mem_state and the internal run flag / branch counter are registered;
// enables, bypass selects and br_taken are decoded combinationally from that
// state and the current instruction pair, as the datapath muxes need them in
// the same cycle.
// ============================================================================
module lc3_pipe_controller #(
    parameter int unsigned BR_PENALTY = 3,
    parameter logic [1:0]  MEM_IDLE   = 2'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  NZP,
    input  logic [2:0]  psr,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2,
    output logic        br_taken,
    output logic [1:0]  mem_state
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned OP_W  = 4;

    localparam logic [OP_W-1:0] OP_BR  = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_W-1:0] OP_LD  = 4'b0010;
    localparam logic [OP_W-1:0] OP_ST  = 4'b0011;
    localparam logic [OP_W-1:0] OP_AND = 4'b0101;
    localparam logic [OP_W-1:0] OP_LDR = 4'b0110;
    localparam logic [OP_W-1:0] OP_STR = 4'b0111;
    localparam logic [OP_W-1:0] OP_NOT = 4'b1001;
    localparam logic [OP_W-1:0] OP_LDI = 4'b1010;
    localparam logic [OP_W-1:0] OP_STI = 4'b1011;
    localparam logic [OP_W-1:0] OP_JMP = 4'b1100;
    localparam logic [OP_W-1:0] OP_LEA = 4'b1110;

    typedef enum logic [1:0] {
        MS_READ  = 2'd0,
        MS_IND   = 2'd1,
        MS_WRITE = 2'd2,
        MS_IDLE  = MEM_IDLE
    } mem_st_e;

    // Opcode class decoders
    function automatic logic is_alu(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_ctrl(input logic [OP_W-1:0] op);
        return (op == OP_BR) || (op == OP_JMP);
    endfunction

    // State: run goes high on the first edge after reset release
    logic               run;
    mem_st_e            mem_st;
    logic [CNT_W-1:0]   br_cnt;

    logic [OP_W-1:0]    op_d;
    logic [OP_W-1:0]    op_e;
    logic               mem_idle;
    logic               br_wait;
    logic               br_first;
    logic               br_final;

    assign op_d     = IR[15:12];
    assign op_e     = IR_Exec[15:12];
    assign mem_idle = (mem_st == MS_IDLE);
    assign br_wait  = (br_cnt != '0);
    assign br_first = (br_cnt == CNT_W'(BR_PENALTY));
    assign br_final = (br_cnt == CNT_W'(1));

    assign mem_state = 2'(mem_st);

    // Stage enables: reset, then memory stall, then branch wait, then fetch stall
    always_comb begin
        enable_updatePC  = 1'b0;
        enable_fetch     = 1'b0;
        enable_decode    = 1'b0;
        enable_execute   = 1'b0;
        enable_writeback = 1'b0;
        if (run) begin
            enable_writeback = mem_idle ||
                               (((mem_st == MS_READ) || (mem_st == MS_WRITE)) && complete_data);
            if (mem_idle) begin
                enable_execute = 1'b1;
                if (br_wait) begin
                    // Redirect cycle updates PC regardless of fetch status
                    enable_updatePC = br_final;
                    enable_decode   = br_first && complete_instr;
                end else begin
                    enable_updatePC = complete_instr;
                    enable_fetch    = complete_instr;
                    enable_decode   = complete_instr;
                end
            end
        end
    end

    // Bypass selects: compare execute destination against decode sources
    logic [2:0] dest;
    logic [2:0] src1;
    logic       src1_used;
    logic       src2_used;
    logic       hit1;
    logic       hit2;
    logic       alu_src;
    logic       mem_src;

    always_comb begin
        dest      = IR_Exec[11:9];
        src1      = is_store(op_d) ? IR[11:9] : IR[8:6];
        src1_used = is_alu(op_d) || (op_d == OP_LDR) || is_store(op_d) || (op_d == OP_JMP);
        src2_used = ((op_d == OP_ADD) || (op_d == OP_AND)) && !IR[5];
        hit1      = src1_used && (dest == src1);
        hit2      = src2_used && (dest == IR[2:0]);
        alu_src   = run && (is_alu(op_e) || (op_e == OP_LEA));
        mem_src   = run && is_load(op_e) && (mem_st == MS_READ) && complete_data;

        bypass_alu_1 = alu_src && hit1;
        bypass_alu_2 = alu_src && hit2;
        bypass_mem_1 = mem_src && hit1 && !bypass_alu_1;
        bypass_mem_2 = mem_src && hit2 && !bypass_alu_2;
    end

    // Branch resolution in execute
    always_comb begin
        br_taken = run && (((op_e == OP_BR) && ((NZP & psr) != 3'b000)) || (op_e == OP_JMP));
    end

    // Memory FSM, branch-penalty counter and run flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run    <= 1'b0;
            mem_st <= MS_IDLE;
            br_cnt <= '0;
        end else begin
            run <= 1'b1;

            case (mem_st)
                MS_IDLE: begin
                    if (enable_execute) begin
                        if ((op_e == OP_LD) || (op_e == OP_LDR)) begin
                            mem_st <= MS_READ;
                        end else if ((op_e == OP_LDI) || (op_e == OP_STI)) begin
                            mem_st <= MS_IND;
                        end else if ((op_e == OP_ST) || (op_e == OP_STR)) begin
                            mem_st <= MS_WRITE;
                        end
                    end
                end
                // Execute is stalled, so IR_Exec still holds the LDI/STI
                MS_IND: begin
                    if (complete_data) begin
                        mem_st <= (op_e == OP_STI) ? MS_WRITE : MS_READ;
                    end
                end
                MS_READ, MS_WRITE: begin
                    if (complete_data) begin
                        mem_st <= MS_IDLE;
                    end
                end
                default: mem_st <= MS_IDLE;
            endcase

            // Counter freezes under memory stall; a new load only once the
            // previous penalty has drained so a wrong-path CTRL cannot extend it
            if (mem_idle) begin
                if (br_wait) begin
                    br_cnt <= br_cnt - CNT_W'(1);
                end else if (enable_decode && is_ctrl(op_d)) begin
                    br_cnt <= CNT_W'(BR_PENALTY);
                end
            end
        end
    end

    // Instruction fields that carry no hazard information
    logic unused_fields;
    assign unused_fields = &{1'b0, IR[4:3], IR_Exec[8:0]};

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Self-checking bench for lc3_pipe_controller.
// Expected output word packing (12 bits):
//   [11] updatePC [10] fetch [9] decode [8] execute [7] writeback
//   [6] alu_1 [5] alu_2 [4] mem_1 [3] mem_2 [2] br_taken [1:0] mem_state
module tb_lc3_pipe_controller;

    logic        clk;
    logic        rst;
    logic        complete_instr;
    logic        complete_data;
    logic [15:0] IR;
    logic [15:0] IR_Exec;
    logic [2:0]  NZP;
    logic [2:0]  psr;
    logic        enable_updatePC;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;
    logic        br_taken;
    logic [1:0]  mem_state;

    lc3_pipe_controller #(.BR_PENALTY(3), .MEM_IDLE(2'd3)) dut (
        .clk              (clk),
        .rst              (rst),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .IR               (IR),
        .IR_Exec          (IR_Exec),
        .NZP              (NZP),
        .psr              (psr),
        .enable_updatePC  (enable_updatePC),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .bypass_alu_1     (bypass_alu_1),
        .bypass_alu_2     (bypass_alu_2),
        .bypass_mem_1     (bypass_mem_1),
        .bypass_mem_2     (bypass_mem_2),
        .br_taken         (br_taken),
        .mem_state        (mem_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [15:0] NOP = 16'hF025;

    // Common expected words
    localparam logic [11:0] E_RST  = 12'h003;  // everything off, idle
    localparam logic [11:0] E_RUN  = 12'hF83;  // all enables, idle
    localparam logic [11:0] E_FSTL = 12'h183;  // fetch stall / branch wait

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic [15:0] irx;
        logic [2:0]  nzp;
        logic [2:0]  psr;
        logic        ci;
        logic        cd;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [11:0] exp;
    } sb_t;

    sb_t  sb[$];
    vec_t tbl[16];
    int   total;
    int   bad;

    function automatic logic [11:0] dut_outs();
        return {enable_updatePC, enable_fetch, enable_decode, enable_execute,
                enable_writeback, bypass_alu_1, bypass_alu_2, bypass_mem_1,
                bypass_mem_2, br_taken, mem_state};
    endfunction

    task automatic check(input string name, input logic [11:0] want);
        logic [11:0] got;
        got   = dut_outs();
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s: got %03h want %03h", name, got, want);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare mid-cycle
    task automatic step(input string name, input logic r, input logic [15:0] ir_v,
                        input logic [15:0] irx_v, input logic [2:0] nzp_v,
                        input logic [2:0] psr_v, input logic ci, input logic cd,
                        input logic [11:0] exp);
        sb_t e;
        rst            = r;
        IR             = ir_v;
        IR_Exec        = irx_v;
        NZP            = nzp_v;
        psr            = psr_v;
        complete_instr = ci;
        complete_data  = cd;
        sb.push_back('{name: name, exp: exp});
        @(negedge clk);
        e = sb.pop_front();
        check(e.name, e.exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; IR = NOP; IR_Exec = NOP; NZP = 3'b000; psr = 3'b010;
        complete_instr = 1'b1; complete_data = 1'b0;

        tbl[0]  = '{"nop",          NOP,     NOP,     3'b000, 3'b010, 1'b1, 1'b0, E_RUN};
        tbl[1]  = '{"alu_fwd_both", 16'h1641, 16'h1242, 3'b000, 3'b010, 1'b1, 1'b0, 12'hFE3};
        tbl[2]  = '{"alu_fwd_imm",  16'h1661, 16'h1242, 3'b000, 3'b010, 1'b1, 1'b0, 12'hFC3};
        tbl[3]  = '{"alu_fwd_src2", 16'h1042, 16'h1400, 3'b000, 3'b010, 1'b1, 1'b0, 12'hFA3};
        tbl[4]  = '{"lea_fwd",      16'h1641, 16'hE200, 3'b000, 3'b010, 1'b1, 1'b0, 12'hFE3};
        tbl[5]  = '{"st_src_hi",    16'h3200, 16'h1242, 3'b000, 3'b010, 1'b1, 1'b0, 12'hFC3};
        tbl[6]  = '{"st_src_lo",    16'h3040, 16'h1242, 3'b000, 3'b010, 1'b1, 1'b0, E_RUN};
        tbl[7]  = '{"ld_no_src",    16'h2040, 16'h1242, 3'b000, 3'b010, 1'b1, 1'b0, E_RUN};
        tbl[8]  = '{"not_src1",     16'h947F, 16'h1242, 3'b000, 3'b010, 1'b1, 1'b0, 12'hFC3};
        tbl[9]  = '{"br_taken",     NOP,     16'h0A03, 3'b101, 3'b001, 1'b1, 1'b0, 12'hF87};
        tbl[10] = '{"br_not_taken", NOP,     16'h0A03, 3'b101, 3'b010, 1'b1, 1'b0, E_RUN};
        tbl[11] = '{"jmp_taken",    NOP,     16'hC1C0, 3'b000, 3'b010, 1'b1, 1'b0, 12'hF87};
        tbl[12] = '{"fetch_stall",  NOP,     NOP,     3'b000, 3'b010, 1'b0, 1'b0, E_FSTL};
        tbl[13] = '{"cd_idle",      NOP,     NOP,     3'b000, 3'b010, 1'b1, 1'b1, E_RUN};
        tbl[14] = '{"and_fwd",      16'h18C3, 16'h56C0, 3'b000, 3'b010, 1'b1, 1'b0, 12'hFE3};
        tbl[15] = '{"str_nomatch",  16'h7240, 16'h1400, 3'b000, 3'b010, 1'b1, 1'b0, E_RUN};

        @(posedge clk);
        #1;

        // Reset held three cycles, released between edges, enables on next edge
        for (int i = 0; i < 3; i++)
            step("rst_hold", 1'b0, NOP, NOP, 3'b000, 3'b010, 1'b1, 1'b0, E_RST);
        step("rst_release", 1'b1, NOP, NOP, 3'b000, 3'b010, 1'b1, 1'b0, E_RST);
        step("first_run",   1'b1, NOP, NOP, 3'b000, 3'b010, 1'b1, 1'b0, E_RUN);

        for (int i = 0; i < 16; i++)
            step(tbl[i].name, 1'b1, tbl[i].ir, tbl[i].irx, tbl[i].nzp, tbl[i].psr,
                 tbl[i].ci, tbl[i].cd, tbl[i].exp);

        // LDI: idle -> indirect -> read -> idle
        step("ldi_issue",   1'b1, NOP, 16'hA205, 3'b000, 3'b010, 1'b1, 1'b0, E_RUN);
        step("ldi_ind",     1'b1, NOP, 16'hA205, 3'b000, 3'b010, 1'b1, 1'b0, 12'h001);
        step("ldi_ind_cd",  1'b1, NOP, 16'hA205, 3'b000, 3'b010, 1'b1, 1'b1, 12'h001);
        step("ldi_read",    1'b1, NOP, 16'hA205, 3'b000, 3'b010, 1'b1, 1'b0, 12'h000);
        step("ldi_read_cd", 1'b1, NOP, 16'hA205, 3'b000, 3'b010, 1'b1, 1'b1, 12'h080);
        step("ldi_done",    1'b1, NOP, NOP,      3'b000, 3'b010, 1'b1, 1'b0, E_RUN);

        // Load-use with immediate second operand
        step("lu_issue",    1'b1, 16'h1261, 16'h6240, 3'b000, 3'b010, 1'b1, 1'b0, E_RUN);
        step("lu_wait",     1'b1, 16'h1261, 16'h6240, 3'b000, 3'b010, 1'b1, 1'b0, 12'h000);
        step("lu_bypass",   1'b1, 16'h1261, 16'h6240, 3'b000, 3'b010, 1'b1, 1'b1, 12'h090);
        step("lu_done",     1'b1, 16'h1261, NOP,      3'b000, 3'b010, 1'b1, 1'b0, E_RUN);

        // ST direct write, STI indirect then write
        step("st_issue",    1'b1, NOP, 16'h3200, 3'b000, 3'b010, 1'b1, 1'b0, E_RUN);
        step("st_write",    1'b1, NOP, 16'h3200, 3'b000, 3'b010, 1'b1, 1'b0, 12'h002);
        step("st_write_cd", 1'b1, NOP, 16'h3200, 3'b000, 3'b010, 1'b1, 1'b1, 12'h082);
        step("st_done",     1'b1, NOP, NOP,      3'b000, 3'b010, 1'b1, 1'b0, E_RUN);
        step("sti_issue",   1'b1, NOP, 16'hB200, 3'b000, 3'b010, 1'b1, 1'b0, E_RUN);
        step("sti_ind_cd",  1'b1, NOP, 16'hB200, 3'b000, 3'b010, 1'b1, 1'b1, 12'h001);
        step("sti_write_cd",1'b1, NOP, 16'hB200, 3'b000, 3'b010, 1'b1, 1'b1, 12'h082);
        step("sti_done",    1'b1, NOP, NOP,      3'b000, 3'b010, 1'b1, 1'b0, E_RUN);

        // Taken BR: three-cycle fetch hold, single br_taken pulse
        step("brt_dec",     1'b1, 16'h0A03, NOP,      3'b000, 3'b001, 1'b1, 1'b0, E_RUN);
        step("brt_pen1",    1'b1, NOP,      16'h0A03, 3'b101, 3'b001, 1'b1, 1'b0, 12'h387);
        step("brt_pen2",    1'b1, NOP,      NOP,      3'b000, 3'b001, 1'b1, 1'b0, E_FSTL);
        step("brt_pen3",    1'b1, NOP,      NOP,      3'b000, 3'b001, 1'b1, 1'b0, 12'h983);
        step("brt_done",    1'b1, NOP,      NOP,      3'b000, 3'b001, 1'b1, 1'b0, E_RUN);

        // Not-taken BR: same stall; redirect cycle overrides a fetch stall
        step("brn_dec",     1'b1, 16'h0A03, NOP,      3'b000, 3'b010, 1'b1, 1'b0, E_RUN);
        step("brn_pen1",    1'b1, NOP,      16'h0A03, 3'b101, 3'b010, 1'b1, 1'b0, 12'h383);
        step("brn_pen2",    1'b1, NOP,      NOP,      3'b000, 3'b010, 1'b0, 1'b0, E_FSTL);
        step("brn_pen3_fs", 1'b1, NOP,      NOP,      3'b000, 3'b010, 1'b0, 1'b0, 12'h983);
        step("brn_done",    1'b1, NOP,      NOP,      3'b000, 3'b010, 1'b1, 1'b0, E_RUN);

        // Memory stall freezes the branch counter
        step("frz_dec",     1'b1, 16'h0A03, NOP,      3'b000, 3'b010, 1'b1, 1'b0, E_RUN);
        step("frz_ld",      1'b1, NOP,      16'h2200, 3'b000, 3'b010, 1'b1, 1'b0, 12'h383);
        step("frz_read",    1'b1, NOP,      16'h2200, 3'b000, 3'b010, 1'b1, 1'b0, 12'h000);
        step("frz_read_cd", 1'b1, NOP,      16'h2200, 3'b000, 3'b010, 1'b1, 1'b1, 12'h080);
        step("frz_cnt2",    1'b1, NOP,      NOP,      3'b000, 3'b010, 1'b1, 1'b0, E_FSTL);
        step("frz_cnt1",    1'b1, NOP,      NOP,      3'b000, 3'b010, 1'b1, 1'b0, 12'h983);
        step("frz_done",    1'b1, NOP,      NOP,      3'b000, 3'b010, 1'b1, 1'b0, E_RUN);

        // Async reset in the middle of an indirect access
        step("ar_issue",    1'b1, NOP, 16'hB200, 3'b000, 3'b010, 1'b1, 1'b0, E_RUN);
        step("ar_ind",      1'b1, NOP, 16'hB200, 3'b000, 3'b010, 1'b1, 1'b0, 12'h001);
        #2;
        rst = 1'b0;
        #1;
        check("ar_async", E_RST);
        @(posedge clk);
        #1;
        step("ar_hold",     1'b0, NOP, NOP, 3'b000, 3'b010, 1'b1, 1'b0, E_RST);
        step("ar_release",  1'b1, NOP, NOP, 3'b000, 3'b010, 1'b1, 1'b0, E_RST);
        step("ar_recover",  1'b1, NOP, NOP, 3'b000, 3'b010, 1'b1, 1'b0, E_RUN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
